// File: rtl/regfile_sweep_reader.sv
// regfile_sweep_reader
//   Read-side sequencer for a 2**ADDR_W x DATA_W dual-read-port register file.
//   A start command sweeps an inclusive, possibly wrapping, address range
//   through both read ports, fetching two registers at a time. Each register
//   leaves as one beat (address + data) on a valid/ready stream. The write
//   port is snooped so that buffered data always matches the register file.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   start                  : sweep request, sampled only while idle
//   first_addr, last_addr  : inclusive sweep range, sampled with start
//   busy                   : sweep in progress (through the done cycle)
//   done                   : one-cycle pulse after the last beat is accepted
//   ra1, ra2 / rd1, rd2    : register file read addresses / read data
//   we, wa, wd             : register file write port (snooped)
//   out_valid, out_ready   : output stream handshake
//   out_addr, out_data     : current beat
module regfile_sweep_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;     // one extra bit: a full sweep counts 2**ADDR_W
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   count;
    logic              handshake;

    // Two-entry fetch buffer; entry 0 is always the older one.
    logic              v0, v1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;

    always_comb begin
        span  = last_addr - first_addr;
        count = {1'b0, span} + (ADDR_W + 1)'(1);
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        out_valid  = (state == S_DRAIN);
        out_addr   = v0 ? a0 : a1;
        out_data   = v0 ? d0 : d1;
        handshake  = out_valid && out_ready;

        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: state_next = S_DRAIN;
            S_DRAIN: begin
                if (handshake) begin
                    if (rem == (ADDR_W + 1)'(1))
                        state_next = S_DONE;
                    else if (!(v0 && v1))
                        state_next = S_FETCH;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ptr   <= '0;
            rem   <= '0;
            ra1   <= '0;
            ra2   <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            a0    <= '0;
            a1    <= '0;
            d0    <= '0;
            d1    <= '0;
        end else begin
            state <= state_next;

            // Keep buffered data coherent with the register file. FETCH
            // overwrites both entries below, so this only matters elsewhere.
            if (we && v0 && (wa == a0)) d0 <= wd;
            if (we && v1 && (wa == a1)) d1 <= wd;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr <= first_addr;
                        rem <= count;
                        ra1 <= first_addr;
                        ra2 <= first_addr + ADDR_W'(1);
                    end
                end
                S_FETCH: begin
                    // A write landing on the same edge is not yet visible on
                    // rd1/rd2, so take the write data directly.
                    v0  <= 1'b1;
                    a0  <= ra1;
                    d0  <= (we && (wa == ra1)) ? wd : rd1;
                    v1  <= (rem >= (ADDR_W + 1)'(2));
                    a1  <= ra2;
                    d1  <= (we && (wa == ra2)) ? wd : rd2;
                    ptr <= ptr + ADDR_W'(2);
                end
                S_DRAIN: begin
                    if (handshake) begin
                        rem <= rem - (ADDR_W + 1)'(1);
                        if (v0) v0 <= 1'b0;
                        else    v1 <= 1'b0;
                        if (state_next == S_FETCH) begin
                            ra1 <= ptr;
                            ra2 <= ptr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sweep_reader.sv
// tb_regfile_sweep_reader
//   Directed bench for regfile_sweep_reader with a behavioural 32x32 register
//   file attached to the read and write ports.
module tb_regfile_sweep_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr, last_addr;
    logic        busy, done;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        out_valid, out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] regs [32] = '{default: '0};

    logic [31:0] b_addr [64];
    logic [31:0] b_data [64];
    int nbeats;
    int ndone;

    regfile_sweep_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .we(we), .wa(wa), .wd(wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (we) regs[wa] <= wd;
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    function automatic logic [31:0] exp_reg(input int a);
        case (a)
            1:  return 32'h11223344;
            2:  return 32'hA5A5A5A5;
            4:  return 32'h14321432;
            8:  return 32'h88888888;
            9:  return 32'hDEADBEEF;
            12: return 32'h12345678;
            31: return 32'hFEDCBA98;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Records accepted beats until done is seen or the budget runs out.
    // rnd selects a random out_ready; a stray start is pulsed at cycle pulse_at.
    task automatic collect(input int budget, input bit rnd, input int pulse_at);
        nbeats = 0;
        ndone  = 0;
        for (int c = 0; c < budget; c++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (c == pulse_at) begin
                start = 1'b1; first_addr = 5'd5; last_addr = 5'd5;
            end else begin
                start = 1'b0;
            end
            if (out_valid && out_ready && nbeats < 64) begin
                b_addr[nbeats] = 32'(out_addr);
                b_data[nbeats] = out_data;
                nbeats++;
            end
            if (done) begin
                ndone++;
                break;
            end
            step();
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int          pa [7];
        logic [31:0] pd [7];
        pa = '{2, 4, 12, 31, 1, 8, 9};
        pd = '{32'hA5A5A5A5, 32'h14321432, 32'h12345678, 32'hFEDCBA98,
               32'h11223344, 32'h88888888, 32'h99999999};

        reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
        we = 1'b0; wa = '0; wd = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ra1", 32'(ra1), 0);
        chk("rst_ra2", 32'(ra2), 0);
        chk("rst_oaddr", 32'(out_addr), 0);
        chk("rst_odata", out_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            we = 1'b1; wa = 5'(pa[i]); wd = pd[i];
            step();
        end
        we = 1'b0;
        chk("idle_busy", 32'(busy), 0);

        // Range 2..4, cycle by cycle
        out_ready = 1'b1; start = 1'b1; first_addr = 5'd2; last_addr = 5'd4;
        step(); start = 1'b0;
        chk("t1_fetch_busy", 32'(busy), 1);
        chk("t1_fetch_valid", 32'(out_valid), 0);
        chk("t1_fetch_ra1", 32'(ra1), 2);
        chk("t1_fetch_ra2", 32'(ra2), 3);
        step();
        chk("t1_b0_valid", 32'(out_valid), 1);
        chk("t1_b0_addr", 32'(out_addr), 2);
        chk("t1_b0_data", out_data, 32'hA5A5A5A5);
        step();
        chk("t1_b1_valid", 32'(out_valid), 1);
        chk("t1_b1_addr", 32'(out_addr), 3);
        chk("t1_b1_data", out_data, 32'h0);
        step();
        chk("t1_fetch2_valid", 32'(out_valid), 0);
        chk("t1_fetch2_ra1", 32'(ra1), 4);
        step();
        chk("t1_b2_addr", 32'(out_addr), 4);
        chk("t1_b2_data", out_data, 32'h14321432);
        step();
        chk("t1_done", 32'(done), 1);
        chk("t1_done_valid", 32'(out_valid), 0);
        chk("t1_done_busy", 32'(busy), 1);
        step();
        chk("t1_after_done", 32'(done), 0);
        chk("t1_after_busy", 32'(busy), 0);

        // Single register
        start = 1'b1; first_addr = 5'd12; last_addr = 5'd12;
        step(); start = 1'b0;
        chk("t2_ra1", 32'(ra1), 12);
        chk("t2_ra2", 32'(ra2), 13);
        collect(20, 1'b0, -1);
        chk("t2_nbeats", 32'(nbeats), 1);
        chk("t2_addr", b_addr[0], 12);
        chk("t2_data", b_data[0], 32'h12345678);
        chk("t2_ndone", 32'(ndone), 1);
        step();
        chk("t2_busy_after", 32'(busy), 0);

        // Wrapping range 31..1
        start = 1'b1; first_addr = 5'd31; last_addr = 5'd1;
        step(); start = 1'b0;
        chk("t3_ra1", 32'(ra1), 31);
        chk("t3_ra2", 32'(ra2), 0);
        collect(30, 1'b0, -1);
        chk("t3_nbeats", 32'(nbeats), 3);
        chk("t3_addr0", b_addr[0], 31);
        chk("t3_data0", b_data[0], 32'hFEDCBA98);
        chk("t3_addr1", b_addr[1], 0);
        chk("t3_data1", b_data[1], 32'h0);
        chk("t3_addr2", b_addr[2], 1);
        chk("t3_data2", b_data[2], 32'h11223344);
        chk("t3_ndone", 32'(ndone), 1);
        step();

        // Backpressure with a write to the buffered second register
        out_ready = 1'b0; start = 1'b1; first_addr = 5'd8; last_addr = 5'd9;
        step(); start = 1'b0;
        step();
        we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_hold_valid%0d", i), 32'(out_valid), 1);
            chk($sformatf("t4_hold_addr%0d", i), 32'(out_addr), 8);
            chk($sformatf("t4_hold_data%0d", i), out_data, 32'h88888888);
            step();
            we = 1'b0;
        end
        out_ready = 1'b1;
        collect(20, 1'b0, -1);
        chk("t4_nbeats", 32'(nbeats), 2);
        chk("t4_addr0", b_addr[0], 8);
        chk("t4_data0", b_data[0], 32'h88888888);
        chk("t4_addr1", b_addr[1], 9);
        chk("t4_data1", b_data[1], 32'hDEADBEEF);
        chk("t4_ndone", 32'(ndone), 1);
        step();

        // Full sweep with random backpressure and a stray start
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
        step(); start = 1'b0;
        collect(400, 1'b1, 10);
        chk("t5_nbeats", 32'(nbeats), 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t5_addr%0d", i), b_addr[i], 32'(i));
            chk($sformatf("t5_data%0d", i), b_data[i], exp_reg(i));
        end
        chk("t5_ndone", 32'(ndone), 1);
        step();
        chk("t5_busy_after", 32'(busy), 0);
        step();
        chk("t5_busy_after2", 32'(busy), 0);

        // Reset in the middle of a sweep
        out_ready = 1'b1; start = 1'b1; first_addr = 5'd0; last_addr = 5'd7;
        step(); start = 1'b0;
        step(); step(); step(); step();
        chk("t6_pre_valid", 32'(out_valid), 1);
        chk("t6_pre_addr", 32'(out_addr), 2);
        reset = 1'b1;
        step();
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_ra1", 32'(ra1), 0);
        chk("t6_oaddr", 32'(out_addr), 0);
        reset = 1'b0;
        step();
        chk("t6_idle_busy", 32'(busy), 0);
        start = 1'b1; first_addr = 5'd2; last_addr = 5'd3;
        step(); start = 1'b0;
        collect(20, 1'b0, -1);
        chk("t6_nbeats", 32'(nbeats), 2);
        chk("t6_addr0", b_addr[0], 2);
        chk("t6_data0", b_data[0], 32'hA5A5A5A5);
        chk("t6_addr1", b_addr[1], 3);
        chk("t6_data1", b_data[1], 32'h0);
        chk("t6_ndone", 32'(ndone), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
